// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// register index type, controller states and stage-mask helpers.
package hazard_ctrl_pkg;

   localparam int NSTAGES = 5;

   typedef enum logic [2:0] {
      STG_F = 3'd0,
      STG_D = 3'd1,
      STG_E = 3'd2,
      STG_M = 3'd3,
      STG_W = 3'd4
   } stage_e;

   typedef logic [4:0] reg_ind_t;

   typedef enum logic [1:0] {
      HC_RUN      = 2'd0,
      HC_MEM_WAIT = 2'd1,
      HC_DRAIN    = 2'd2
   } hctrl_state_e;

   // Bits F..s set: the stages held when s is the deepest stalled stage.
   function automatic logic [NSTAGES-1:0] upto_mask(input stage_e s);
      logic [NSTAGES-1:0] m;
      m = '0;
      for (int i = 0; i < NSTAGES; i++) begin
         m[i] = (i <= int'(s));
      end
      return m;
   endfunction

   function automatic logic [NSTAGES-1:0] stage_bit(input stage_e s);
      return NSTAGES'(1) << s;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the D instruction reads a register that the load
// currently in E has not yet produced.
module hazard_detect
   import hazard_ctrl_pkg::*;
(
   input  reg_ind_t i_id_rs1,
   input  reg_ind_t i_id_rs2,
   input  logic     i_id_use_rs1,
   input  logic     i_id_use_rs2,
   input  reg_ind_t i_ex_rd,
   input  logic     i_ex_is_load,
   output logic     o_load_use
);

   logic w_hit_rs1;
   logic w_hit_rs2;

   assign w_hit_rs1  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
   assign w_hit_rs2  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
   // x0 is hardwired zero, so a load targeting it never creates a hazard.
   assign o_load_use = i_ex_is_load & (i_ex_rd != 5'd0) & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the F/D/E/M/W pipeline: load-use,
// redirects, data-memory waits with watchdog, multi-cycle EX and fences.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  reg_ind_t           i_id_rs1,
   input  reg_ind_t           i_id_rs2,
   input  logic               i_id_use_rs1,
   input  logic               i_id_use_rs2,
   input  logic               i_id_fence,
   input  reg_ind_t           i_ex_rd,
   input  logic               i_ex_is_load,
   input  logic               i_ex_busy,
   input  logic               i_ex_redirect,
   input  logic               i_mem_req,
   input  logic               i_mem_ready,
   input  logic [NSTAGES-1:0] i_stage_valid,
   output logic [NSTAGES-1:0] o_stalls,
   output logic [NSTAGES-1:0] o_flushes,
   output logic               o_fence_done,
   output logic               o_mem_abort,
   output logic [CNT_W-1:0]   o_stall_cnt
);

   localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   hctrl_state_e       r_state;
   hctrl_state_e       w_state_nxt;
   logic               r_pend_redir;
   logic               w_pend_nxt;
   logic [WD_W-1:0]    r_wd_cnt;
   logic [WD_W-1:0]    w_wd_nxt;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [NSTAGES-1:0] w_stalls;
   logic [NSTAGES-1:0] w_flushes;
   logic               w_fence_done;
   logic               w_mem_abort;
   logic               w_load_use;
   logic               w_drained;
   logic               w_wd_expired;

   hazard_detect u_detect (
      .i_id_rs1     (i_id_rs1),
      .i_id_rs2     (i_id_rs2),
      .i_id_use_rs1 (i_id_use_rs1),
      .i_id_use_rs2 (i_id_use_rs2),
      .i_ex_rd      (i_ex_rd),
      .i_ex_is_load (i_ex_is_load),
      .o_load_use   (w_load_use)
   );

   assign w_drained    = ~|(i_stage_valid & ~upto_mask(STG_D));
   assign w_wd_expired = (MEM_TIMEOUT != 0) && (r_wd_cnt == MEM_TIMEOUT[WD_W-1:0]);

   // Next-state and stall/flush encoding for the current cycle.
   always_comb begin
      w_stalls     = '0;
      w_flushes    = '0;
      w_fence_done = 1'b0;
      w_mem_abort  = 1'b0;
      w_state_nxt  = r_state;
      w_pend_nxt   = r_pend_redir;
      w_wd_nxt     = r_wd_cnt;
      case (r_state)
         HC_RUN: begin
            w_wd_nxt   = '0;
            w_pend_nxt = 1'b0;
            if (i_ex_redirect | r_pend_redir) begin
               w_flushes = upto_mask(STG_D);
            end else if (i_mem_req & ~i_mem_ready) begin
               w_stalls    = upto_mask(STG_M);
               w_flushes   = stage_bit(STG_W);
               w_state_nxt = HC_MEM_WAIT;
               w_wd_nxt    = WD_W'(1);
            end else if (i_ex_busy) begin
               w_stalls  = upto_mask(STG_E);
               w_flushes = stage_bit(STG_M);
            end else if (w_load_use) begin
               w_stalls  = upto_mask(STG_D);
               w_flushes = stage_bit(STG_E);
            end else if (i_id_fence & w_drained) begin
               w_fence_done = 1'b1;
            end else if (i_id_fence) begin
               w_stalls    = upto_mask(STG_D);
               w_flushes   = stage_bit(STG_E);
               w_state_nxt = HC_DRAIN;
            end else begin
               w_state_nxt = HC_RUN;
            end
         end
         HC_MEM_WAIT: begin
            // A redirect resolved while frozen is replayed on the first RUN cycle.
            if (i_mem_ready) begin
               w_state_nxt = HC_RUN;
               w_wd_nxt    = '0;
               w_pend_nxt  = r_pend_redir | i_ex_redirect;
            end else if (w_wd_expired) begin
               w_mem_abort = 1'b1;
               w_flushes   = upto_mask(STG_M);
               w_state_nxt = HC_RUN;
               w_wd_nxt    = '0;
               w_pend_nxt  = 1'b0;
            end else begin
               w_stalls   = upto_mask(STG_M);
               w_flushes  = stage_bit(STG_W);
               w_pend_nxt = r_pend_redir | i_ex_redirect;
               w_wd_nxt   = (r_wd_cnt == {WD_W{1'b1}}) ? r_wd_cnt : r_wd_cnt + WD_W'(1);
            end
         end
         HC_DRAIN: begin
            if (i_ex_redirect) begin
               w_flushes   = upto_mask(STG_D);
               w_state_nxt = HC_RUN;
            end else if (w_drained) begin
               w_fence_done = 1'b1;
               w_state_nxt  = HC_RUN;
            end else begin
               w_stalls  = upto_mask(STG_D);
               w_flushes = stage_bit(STG_E);
            end
         end
         default: begin
            w_flushes   = '1;
            w_state_nxt = HC_RUN;
            w_pend_nxt  = 1'b0;
            w_wd_nxt    = '0;
         end
      endcase
   end

   assign o_stalls     = i_rst ? '0   : w_stalls;
   assign o_flushes    = i_rst ? '1   : w_flushes;
   assign o_fence_done = i_rst ? 1'b0 : w_fence_done;
   assign o_mem_abort  = i_rst ? 1'b0 : w_mem_abort;
   assign o_stall_cnt  = r_stall_cnt;

   // Controller state, watchdog, pending redirect and saturating stall counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= HC_RUN;
         r_pend_redir <= 1'b0;
         r_wd_cnt     <= '0;
         r_stall_cnt  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pend_redir <= w_pend_nxt;
         r_wd_cnt     <= w_wd_nxt;
         if (w_stalls[STG_F] && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a behavioural
// model expressed as "deepest held stage" plus wait/drain bookkeeping.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int TO = 4;
   localparam int CW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, use1, use2, fence, is_load, busy, redirect, mem_req, mem_ready;
   reg_ind_t rs1, rs2, ex_rd;
   logic [4:0] valid;
   logic [4:0] stalls, flushes;
   logic fence_done, mem_abort;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int failures = 0;

   // behavioural model state
   bit m_wait, m_drain, m_owed;
   int m_wcyc, m_cnt;
   logic [4:0] e_st, e_fl;
   logic e_done, e_abort;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_id_rs1(rs1), .i_id_rs2(rs2),
      .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_id_fence(fence),
      .i_ex_rd(ex_rd), .i_ex_is_load(is_load), .i_ex_busy(busy),
      .i_ex_redirect(redirect), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
      .i_stage_valid(valid), .o_stalls(stalls), .o_flushes(flushes),
      .o_fence_done(fence_done), .o_mem_abort(mem_abort), .o_stall_cnt(stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0; fence = 1'b0;
      ex_rd = 5'd0; is_load = 1'b0; busy = 1'b0; redirect = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0; valid = 5'd0;
   endtask

   // Expected outputs for this cycle from the rules, then advance model state.
   task automatic model_eval();
      int depth;
      bit lu, empty;
      depth = -1; e_fl = 5'd0; e_done = 1'b0; e_abort = 1'b0;
      lu = is_load && (ex_rd != 0) && ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
      empty = (valid[4:2] == 3'd0);
      if (rst) begin
         e_fl = 5'b11111;
         m_wait = 0; m_drain = 0; m_owed = 0; m_wcyc = 0;
      end else if (m_wait) begin
         if (mem_ready) begin
            m_wait = 0; m_owed = m_owed | redirect;
         end else if (m_wcyc == TO) begin
            e_abort = 1'b1; e_fl = 5'b01111; m_wait = 0; m_owed = 0;
         end else begin
            depth = 3; m_owed = m_owed | redirect; m_wcyc++;
         end
      end else if (m_drain) begin
         if (redirect) begin
            e_fl = 5'b00011; m_drain = 0;
         end else if (empty) begin
            e_done = 1'b1; m_drain = 0;
         end else depth = 1;
      end else begin
         if (redirect || m_owed) e_fl = 5'b00011;
         else if (mem_req && !mem_ready) begin depth = 3; m_wait = 1; m_wcyc = 1; end
         else if (busy) depth = 2;
         else if (lu) depth = 1;
         else if (fence && empty) e_done = 1'b1;
         else if (fence) begin depth = 1; m_drain = 1; end
         m_owed = 0;
      end
      e_st = (depth < 0) ? 5'd0 : 5'((1 << (depth + 1)) - 1);
      if (depth >= 0 && depth < 4) e_fl = e_fl | 5'(1 << (depth + 1));
      if (rst) m_cnt = 0;
      else if (depth >= 0 && m_cnt < (1 << CW) - 1) m_cnt++;
   endtask

   task automatic eval(input string tag);
      #1;
      model_eval();
      check({tag, "_stalls"}, 32'(stalls), 32'(e_st));
      check({tag, "_flushes"}, 32'(flushes), 32'(e_fl));
      check({tag, "_fence_done"}, 32'(fence_done), 32'(e_done));
      check({tag, "_mem_abort"}, 32'(mem_abort), 32'(e_abort));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
      @(negedge clk);
   endtask

   initial begin
      int cnt0;
      idle();
      m_cnt = 0;
      @(negedge clk);

      rst = 1'b1;
      eval("reset");
      check("reset_flush_all", 32'(flushes), 32'h1F);
      tick("reset");
      check("reset_cnt_zero", 32'(stall_cnt), 32'd0);
      idle();
      eval("idle"); tick("idle");

      // load-use on rs1, then ex_rd=0 must not stall
      is_load = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
      eval("lu");
      check("lu_const_st", 32'(stalls), 32'h03);
      check("lu_const_fl", 32'(flushes), 32'h04);
      tick("lu");
      ex_rd = 5'd0; rs1 = 5'd0;
      eval("lu_x0");
      check("lu_x0_const", 32'(stalls), 32'h00);
      tick("lu_x0");

      // redirect beats load-use
      ex_rd = 5'd5; rs1 = 5'd5; redirect = 1'b1;
      eval("redir_lu");
      check("redir_lu_const", 32'(flushes), 32'h03);
      tick("redir_lu");
      idle();

      // memory wait of three cycles
      cnt0 = m_cnt;
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         eval("mw");
         check("mw_const_st", 32'(stalls), 32'h0F);
         check("mw_const_fl", 32'(flushes), 32'h10);
         tick("mw");
      end
      mem_ready = 1'b1;
      eval("mw_rel");
      check("mw_rel_const", 32'(stalls), 32'h00);
      tick("mw_rel");
      check("mw_cnt_plus3", 32'(stall_cnt), 32'(cnt0 + 3));
      idle();

      // redirect during the wait is replayed after release
      mem_req = 1'b1;
      eval("pr0"); tick("pr0");
      eval("pr1"); tick("pr1");
      redirect = 1'b1;
      eval("pr2"); tick("pr2");
      redirect = 1'b0; mem_ready = 1'b1;
      eval("pr_rel"); tick("pr_rel");
      idle();
      eval("pr_apply");
      check("pr_apply_const", 32'(flushes), 32'h03);
      tick("pr_apply");

      // fence drains E/M over two cycles
      fence = 1'b1; valid = 5'b01100;
      eval("fn0"); tick("fn0");
      valid = 5'b01000;
      eval("fn1");
      check("fn1_const", 32'(stalls), 32'h03);
      tick("fn1");
      valid = 5'b00000;
      eval("fn_done");
      check("fn_done_const", 32'(fence_done), 32'd1);
      tick("fn_done");
      eval("fn_empty"); tick("fn_empty");
      idle();

      // watchdog expiry
      mem_req = 1'b1;
      for (int i = 0; i < 4; i++) begin eval("wd"); tick("wd"); end
      eval("wd_abort");
      check("wd_abort_const", 32'(mem_abort), 32'd1);
      check("wd_abort_fl_const", 32'(flushes), 32'h0F);
      tick("wd_abort");
      idle();
      eval("wd_after"); tick("wd_after");

      // reset in the middle of a wait
      mem_req = 1'b1;
      eval("rw0"); tick("rw0");
      eval("rw1"); tick("rw1");
      rst = 1'b1;
      eval("rw_rst");
      check("rw_rst_abort_const", 32'(mem_abort), 32'd0);
      tick("rw_rst");
      idle();
      eval("rw_after"); tick("rw_after");

      // counter saturation
      busy = 1'b1;
      for (int i = 0; i < 260; i++) begin eval("sat"); tick("sat"); end
      check("sat_const", 32'(stall_cnt), 32'hFF);
      idle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         rs1       = 5'($urandom_range(0, 3));
         rs2       = 5'($urandom_range(0, 3));
         ex_rd     = 5'($urandom_range(0, 3));
         use1      = $urandom_range(0, 1) == 1;
         use2      = $urandom_range(0, 1) == 1;
         is_load   = $urandom_range(0, 2) == 0;
         busy      = $urandom_range(0, 5) == 0;
         redirect  = $urandom_range(0, 7) == 0;
         fence     = $urandom_range(0, 3) == 0;
         mem_req   = $urandom_range(0, 2) == 0;
         mem_ready = $urandom_range(0, 2) != 0;
         if ($urandom_range(0, 9) == 0) mem_ready = 1'b0;
         valid     = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) valid = valid & 5'b00011;
         eval("rnd"); tick("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
